spi_flash_responder: RTL and testbench
======================================

SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

Interface
REQ-001 Parameter: JEDEC_ID, default 24'hEF4018, the 3-byte ID returned for command 0x9F, MSB byte first.
REQ-002 Port: clock, input, 1, system clock; must run at least 8x the SPI sclk frequency.
REQ-003 Port: reset_n, input, 1, asynchronous active-low reset.
REQ-004 Port: spi_csn, input, 1, chip select from the SPI initiator, active low.
REQ-005 Port: spi_sclk, input, 1, SPI clock, mode 0 (idle low).
REQ-006 Port: spi_mosi, input, 1, initiator-to-responder serial data.
REQ-007 Port: spi_miso, output, 1, responder-to-initiator serial data.
REQ-008 Port: spi_miso_oe, output, 1, output enable for spi_miso; high only in the DATA or ID state with spi_csn low.
REQ-009 Port: mem_req, output, 1, single-cycle pulse requesting the byte at mem_addr.
REQ-010 Port: mem_addr, output, 24, byte address of the current request; held stable until the next request.
REQ-011 Port: mem_ack, input, 1, single-cycle pulse: mem_rdata is valid.
REQ-012 Port: mem_rdata, input, 8, byte returned on mem_ack.
REQ-013 Port: busy, output, 1, high while any state other than IDLE is active.
REQ-014 Port: underrun, output, 1, sticky flag: a data byte was needed before mem_ack arrived.

Function
REQ-015 spi_csn, spi_sclk and spi_mosi shall pass through 2-flop synchronizers; sclk edges are detected on the synchronized signal.
REQ-016 spi_mosi shall be sampled on each detected sclk rising edge, MSB first; spi_miso shall change only on detected sclk falling edges, or on state entry as stated in REQ-020.
REQ-017 States: IDLE, CMD, ADDR, DATA, ID, IGNORE.
REQ-018 IDLE->CMD shall occur on a synchronized spi_csn falling edge, clearing the bit counter.
REQ-019 In CMD, after 8 bits:
- 0x03 -> ADDR
- 0x9F -> ID
- any other value, including 0xAB -> IGNORE
REQ-020 In ID, byte k (k=0..2) of JEDEC_ID shall be shifted out; bit 7 of byte 0 shall be driven on the falling edge that follows the 8th command bit. After 3 bytes, spi_miso shall be 1 for the remainder of the transaction.
REQ-021 In ADDR, 24 bits shall be collected MSB first; on the rising edge of the 24th bit, mem_addr shall be set to the collected address, mem_req shall pulse, and the state shall go to DATA.
REQ-022 In DATA, the byte latched from mem_rdata shall be shifted out MSB first; bit 7 shall be driven on the falling edge after the byte load.
REQ-023 On the rising edge of bit 0 of each DATA byte, mem_addr shall increment by 1 (modulo 2^24, so 24'hFFFFFF wraps to 0) and mem_req shall pulse.
REQ-024 If mem_ack has not arrived by the falling edge on which a new byte must start, that byte shall be 8'hFF and underrun shall set; a late mem_ack for that request shall be discarded.
REQ-025 mem_ack arriving while no request is outstanding shall be ignored.
REQ-026 IGNORE shall hold spi_miso_oe low and discard all bits until spi_csn rises.
REQ-027 A synchronized spi_csn rising edge in any state shall force IDLE within 1 clock and drop spi_miso_oe; an outstanding request's mem_ack shall be discarded.
REQ-028 A partial byte at deassertion shall be discarded, with no request or state side effects.
REQ-029 underrun shall clear only on reset.

Reset
REQ-030 On reset_n low, asynchronously:
- state = IDLE
- spi_miso = 1
- spi_miso_oe = 0
- mem_req = 0
- mem_addr = 0
- busy = 0
- underrun = 0
- synchronizers preset to csn=1, sclk=0
REQ-031 reset_n asserted mid-transaction shall abort it; after release, the responder shall wait for a fresh spi_csn falling edge.

Verification
REQ-032 Send 0x03, address 0x000010, read 4 bytes with memory returning addr[7:0] after a 2-cycle latency -> spi_miso bytes 0x10,0x11,0x12,0x13; mem_req pulses 4 or 5 times; underrun=0.
REQ-033 Send 0x9F, read 4 bytes -> 0xEF,0x40,0x18,0xFF.
REQ-034 Send 0x03, address 0xFFFFFF, read 2 bytes -> mem_addr sequence 0xFFFFFF then 0x000000.
REQ-035 Memory latency exceeds one sclk period -> byte reads 0xFF and underrun=1 until reset.
REQ-036 Send 0xAB, then raise csn, then send 0x03 with address 0x000000 -> spi_miso_oe=0 during 0xAB; the read then returns the byte at address 0.
REQ-037 Raise csn after 12 address bits, then start a new read -> IDLE within 1 clock, no mem_req issued, and the new read is correct.

Source files
------------

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash responder: serves READ (0x03) from an external byte memory
// and READ-ID (0x9F) from a parameter; other commands are silently ignored.
module spi_flash_responder #(
    parameter logic [23:0] JEDEC_ID = 24'hEF4018
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        spi_csn,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic        mem_req,
    output logic [23:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        busy,
    output logic        underrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_ID,
        S_IGNORE
    } state_t;

    state_t state_reg, state_next;

    // [0],[1] synchronizer stages, [2] previous value for edge detection
    logic [2:0]  csn_pipe_reg;
    logic [2:0]  sclk_pipe_reg;
    logic [1:0]  mosi_pipe_reg;
    logic        warm_reg;
    logic        armed_reg;

    logic [23:0] shift_reg;
    logic [4:0]  bit_cnt_reg;
    logic [7:0]  tx_shift_reg;
    logic [2:0]  tx_cnt_reg;
    logic [1:0]  byte_idx_reg;
    logic [7:0]  data_reg;
    logic        valid_reg;
    logic        pending_reg;
    logic        miso_reg;
    logic        req_reg;
    logic [23:0] addr_reg;
    logic        underrun_reg;

    logic [7:0]  id_bytes [4];

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_id_bytes
            assign id_bytes[gi] = JEDEC_ID[23 - 8*gi -: 8];
        end
    endgenerate
    assign id_bytes[3] = 8'hFF;

    logic        csn_s, csn_fall, csn_rise;
    logic        sclk_rise, sclk_fall, mosi_s;
    logic [23:0] rx_word;
    logic        cmd_done, addr_done, tx_active, byte_start;
    logic        ack_take, data_ready, next_req;
    logic [7:0]  next_byte;

    assign csn_s     = csn_pipe_reg[1];
    // A falling edge only counts once csn has really been seen high since reset
    assign csn_fall  = armed_reg & csn_pipe_reg[2] & ~csn_pipe_reg[1];
    assign csn_rise  = ~csn_pipe_reg[2] & csn_pipe_reg[1];
    assign sclk_rise = sclk_pipe_reg[1] & ~sclk_pipe_reg[2];
    assign sclk_fall = ~sclk_pipe_reg[1] & sclk_pipe_reg[2];
    assign mosi_s    = mosi_pipe_reg[1];

    assign rx_word    = {shift_reg[22:0], mosi_s};
    assign cmd_done   = (state_reg == S_CMD)  && sclk_rise && (bit_cnt_reg == 5'd7);
    assign addr_done  = (state_reg == S_ADDR) && sclk_rise && (bit_cnt_reg == 5'd23);
    assign tx_active  = (state_reg == S_DATA) || (state_reg == S_ID);
    assign byte_start = tx_active && sclk_fall && (tx_cnt_reg == 3'd0);
    assign ack_take   = mem_ack && pending_reg;
    assign data_ready = ack_take || valid_reg;
    assign next_req   = (state_reg == S_DATA) && sclk_rise && (tx_cnt_reg == 3'd0);

    always_comb begin
        next_byte = 8'hFF;
        if (state_reg == S_ID) begin
            next_byte = id_bytes[byte_idx_reg];
        end else if (ack_take) begin
            next_byte = mem_rdata;
        end else if (valid_reg) begin
            next_byte = data_reg;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (csn_rise) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: if (csn_fall) state_next = S_CMD;
                S_CMD: begin
                    if (cmd_done) begin
                        case (rx_word[7:0])
                            8'h03:   state_next = S_ADDR;
                            8'h9F:   state_next = S_ID;
                            default: state_next = S_IGNORE;
                        endcase
                    end
                end
                S_ADDR: if (addr_done) state_next = S_DATA;
                default: state_next = state_reg;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            csn_pipe_reg  <= 3'b111;
            sclk_pipe_reg <= 3'b000;
            mosi_pipe_reg <= 2'b00;
            warm_reg      <= 1'b0;
            armed_reg     <= 1'b0;
        end else begin
            csn_pipe_reg  <= {csn_pipe_reg[1:0], spi_csn};
            sclk_pipe_reg <= {sclk_pipe_reg[1:0], spi_sclk};
            mosi_pipe_reg <= {mosi_pipe_reg[0], spi_mosi};
            warm_reg      <= 1'b1;
            armed_reg     <= armed_reg | (warm_reg & csn_pipe_reg[0]);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
            tx_shift_reg <= 8'hFF;
            tx_cnt_reg   <= '0;
            byte_idx_reg <= '0;
            data_reg     <= '0;
            valid_reg    <= 1'b0;
            pending_reg  <= 1'b0;
            miso_reg     <= 1'b1;
            req_reg      <= 1'b0;
            addr_reg     <= '0;
            underrun_reg <= 1'b0;
        end else begin
            req_reg <= 1'b0;

            if ((state_reg == S_IDLE) && csn_fall) begin
                bit_cnt_reg <= '0;
            end
            if (sclk_rise && ((state_reg == S_CMD) || (state_reg == S_ADDR))) begin
                shift_reg   <= rx_word;
                bit_cnt_reg <= bit_cnt_reg + 5'd1;
            end
            if (cmd_done) begin
                bit_cnt_reg  <= '0;
                tx_cnt_reg   <= '0;
                byte_idx_reg <= '0;
            end

            if (ack_take) begin
                data_reg    <= mem_rdata;
                valid_reg   <= 1'b1;
                pending_reg <= 1'b0;
            end

            if (addr_done || next_req) begin
                addr_reg    <= addr_done ? rx_word : addr_reg + 24'd1;
                req_reg     <= 1'b1;
                pending_reg <= 1'b1;
                valid_reg   <= 1'b0;
            end

            if (tx_active && sclk_fall) begin
                if (byte_start) begin
                    miso_reg     <= next_byte[7];
                    tx_shift_reg <= {next_byte[6:0], 1'b1};
                    tx_cnt_reg   <= 3'd7;
                    if (state_reg == S_ID) begin
                        if (byte_idx_reg != 2'd3) byte_idx_reg <= byte_idx_reg + 2'd1;
                    end else begin
                        // Whatever was fetched is consumed; a late ack is now stale
                        valid_reg   <= 1'b0;
                        pending_reg <= 1'b0;
                        if (!data_ready) underrun_reg <= 1'b1;
                    end
                end else begin
                    miso_reg     <= tx_shift_reg[7];
                    tx_shift_reg <= {tx_shift_reg[6:0], 1'b1};
                    tx_cnt_reg   <= tx_cnt_reg - 3'd1;
                end
            end

            if (csn_rise) begin
                miso_reg    <= 1'b1;
                pending_reg <= 1'b0;
                valid_reg   <= 1'b0;
                tx_cnt_reg  <= '0;
            end
        end
    end

    assign spi_miso    = miso_reg;
    assign spi_miso_oe = tx_active & ~csn_s;
    assign mem_req     = req_reg;
    assign mem_addr    = addr_reg;
    assign busy        = (state_reg != S_IDLE);
    assign underrun    = underrun_reg;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: SPI initiator, latency-configurable
// byte memory, and a queue of expected MISO bytes.
module tb_spi_flash_responder;

    localparam int HALF = 8;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        spi_csn = 1'b1;
    logic        spi_sclk = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;
    logic        busy;
    logic        underrun;

    int          tests = 0;
    int          failures = 0;
    int          mem_latency = 2;
    logic [7:0]  mem_off = 8'h00;
    logic [23:0] mem_cur;
    int          req_count = 0;
    logic [23:0] req_addr_q[$];
    logic [7:0]  exp_q[$];
    logic        oe_any = 1'b0;

    always #5 clock = ~clock;

    spi_flash_responder #(.JEDEC_ID(24'hEF4018)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .spi_csn     (spi_csn),
        .spi_sclk    (spi_sclk),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .busy        (busy),
        .underrun    (underrun)
    );

    always @(negedge clock) begin
        if (mem_req) begin
            req_count++;
            req_addr_q.push_back(mem_addr);
        end
    end

    // Byte memory: returns addr[7:0] + mem_off after mem_latency cycles
    initial begin
        forever begin
            @(negedge clock);
            if (mem_req) begin
                mem_cur = mem_addr;
                repeat (mem_latency - 1) @(negedge clock);
                mem_ack   = 1'b1;
                mem_rdata = mem_cur[7:0] + mem_off;
                @(negedge clock);
                mem_ack   = 1'b0;
                mem_rdata = 8'h00;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = nbits - 1; i >= 0; i--) begin
            spi_mosi = tx[i];
            repeat (HALF) @(negedge clock);
            spi_sclk = 1'b1;
            rx = {rx[6:0], spi_miso};
            if (spi_miso_oe) oe_any = 1'b1;
            repeat (HALF) @(negedge clock);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic cs_low();
        spi_csn = 1'b0;
        oe_any  = 1'b0;
        repeat (HALF) @(negedge clock);
    endtask

    task automatic cs_high();
        repeat (HALF) @(negedge clock);
        spi_csn = 1'b1;
        repeat (2 * HALF) @(negedge clock);
    endtask

    task automatic read_bytes(input int nbytes, input string tag);
        logic [7:0] rx;
        logic [7:0] exp;
        for (int b = 0; b < nbytes; b++) begin
            spi_bits(8'h00, 8, rx);
            if (exp_q.size() > 0) exp = exp_q.pop_front();
            else exp = ~rx;
            check($sformatf("%s_byte%0d", tag, b), 32'(rx), 32'(exp));
        end
        $display("[TB] %s: %0d bytes received", tag, nbytes);
    endtask

    task automatic send_read_cmd(input logic [23:0] addr);
        logic [7:0] rx;
        spi_bits(8'h03, 8, rx);
        spi_bits(addr[23:16], 8, rx);
        spi_bits(addr[15:8], 8, rx);
        spi_bits(addr[7:0], 8, rx);
    endtask

    task automatic do_read(input logic [23:0] addr, input int nbytes, input string tag);
        cs_low();
        send_read_cmd(addr);
        read_bytes(nbytes, tag);
        cs_high();
    endtask

    initial begin
        int         req_before;
        logic [7:0] rx;

        // Reset state
        repeat (4) @(negedge clock);
        check("rst_miso", 32'(spi_miso), 32'(1'b1));
        check("rst_oe", 32'(spi_miso_oe), 32'(1'b0));
        check("rst_req", 32'(mem_req), 32'(1'b0));
        check("rst_addr", 32'(mem_addr), 32'(24'h0));
        check("rst_busy", 32'(busy), 32'(1'b0));
        check("rst_underrun", 32'(underrun), 32'(1'b0));
        reset_n = 1'b1;
        repeat (10) @(negedge clock);

        // Read 4 bytes at 0x10, memory returns addr[7:0]
        mem_off = 8'h00;
        req_addr_q.delete();
        req_before = req_count;
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h10 + 8'(i));
        do_read(24'h000010, 4, "read_0x10");
        check("read_0x10_req_4or5", 32'((req_count - req_before == 4) || (req_count - req_before == 5)), 32'(1'b1));
        check("read_0x10_first_addr", 32'((req_addr_q.size() > 0) ? req_addr_q[0] : 24'hxxxxxx), 32'(24'h000010));
        check("read_0x10_underrun", 32'(underrun), 32'(1'b0));

        // JEDEC ID
        exp_q.push_back(8'hEF);
        exp_q.push_back(8'h40);
        exp_q.push_back(8'h18);
        exp_q.push_back(8'hFF);
        cs_low();
        spi_bits(8'h9F, 8, rx);
        read_bytes(4, "read_id");
        check("read_id_oe", 32'(oe_any), 32'(1'b1));
        cs_high();

        // Address wrap
        mem_off = 8'h21;
        req_addr_q.delete();
        exp_q.push_back(8'hFF + 8'h21);
        exp_q.push_back(8'h00 + 8'h21);
        do_read(24'hFFFFFF, 2, "read_wrap");
        check("wrap_nreq", 32'(req_addr_q.size() >= 2), 32'(1'b1));
        if (req_addr_q.size() >= 2) begin
            check("wrap_addr0", 32'(req_addr_q[0]), 32'(24'hFFFFFF));
            check("wrap_addr1", 32'(req_addr_q[1]), 32'(24'h000000));
        end

        // Unsupported command, then a read of address 0
        cs_low();
        spi_bits(8'hAB, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'h00, 8, rx);
        check("ignore_oe", 32'(oe_any), 32'(1'b0));
        check("ignore_busy", 32'(busy), 32'(1'b1));
        cs_high();
        $display("[TB] cmd_0xAB: ignored");
        exp_q.push_back(8'h00 + 8'h21);
        do_read(24'h000000, 1, "read_after_ab");

        // Abort after 12 address bits
        req_before = req_count;
        cs_low();
        spi_bits(8'h03, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'h01, 4, rx);
        check("abort_busy_before", 32'(busy), 32'(1'b1));
        repeat (HALF) @(negedge clock);
        spi_csn = 1'b1;
        repeat (4) @(negedge clock);
        check("abort_busy_after", 32'(busy), 32'(1'b0));
        check("abort_oe_after", 32'(spi_miso_oe), 32'(1'b0));
        check("abort_no_req", 32'(req_count - req_before), 32'(0));
        repeat (2 * HALF) @(negedge clock);
        $display("[TB] abort_12_bits: done");
        exp_q.push_back(8'h23 + 8'h21);
        exp_q.push_back(8'h24 + 8'h21);
        do_read(24'h000123, 2, "read_after_abort");

        // Memory latency longer than an sclk period
        mem_latency = 24;
        for (int i = 0; i < 3; i++) exp_q.push_back(8'hFF);
        do_read(24'h000040, 3, "read_slow");
        check("slow_underrun", 32'(underrun), 32'(1'b1));
        repeat (40) @(negedge clock);
        mem_latency = 2;
        exp_q.push_back(8'h50 + 8'h21);
        do_read(24'h000050, 1, "read_after_slow");
        check("underrun_sticky", 32'(underrun), 32'(1'b1));

        // Reset mid-transaction with csn held low
        cs_low();
        spi_bits(8'h03, 8, rx);
        spi_bits(8'h00, 8, rx);
        check("midrst_busy_before", 32'(busy), 32'(1'b1));
        reset_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'(1'b0));
        check("midrst_underrun", 32'(underrun), 32'(1'b0));
        check("midrst_miso", 32'(spi_miso), 32'(1'b1));
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (40) @(negedge clock);
        check("midrst_wait_fresh_edge", 32'(busy), 32'(1'b0));
        spi_csn = 1'b1;
        repeat (2 * HALF) @(negedge clock);
        $display("[TB] reset_mid_transaction: done");
        exp_q.push_back(8'h07 + 8'h21);
        do_read(24'h000007, 1, "read_after_reset");
        check("final_underrun", 32'(underrun), 32'(1'b0));

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
